univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/shift_pkg.sv | 15 +
 rtl/dff_ar.sv | 25 ++
 rtl/univ_shift_reg.sv | 90 +++++++++
 tb/tb_univ_shift_reg.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared operation codes for the universal shift register, used by RTL and bench.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_CLR  = 3'd7
    } mode_e;

endpackage

// File: rtl/dff_ar.sv
// Parametrised register with asynchronous active-high reset, clock enable and reset value.
module dff_ar #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, load, logical/arithmetic shifts, rotates and clear,
// with a registered shift-out bit and a combinational zero flag.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             zero
);

    logic [WIDTH-1:0] q_d;
    logic             sout_d;

    // sout keeps its value unless a bit actually leaves the register (or CLR wipes it).
    always_comb begin
        q_d    = q;
        sout_d = sout;
        case (mode_e'(mode))
            MODE_HOLD: begin
                q_d = q;
            end
            MODE_LOAD: begin
                q_d = d;
            end
            MODE_SHL: begin
                q_d    = {q[WIDTH-2:0], sin_l};
                sout_d = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_d    = {sin_r, q[WIDTH-1:1]};
                sout_d = q[0];
            end
            MODE_ROL: begin
                q_d    = {q[WIDTH-2:0], q[WIDTH-1]};
                sout_d = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_d    = {q[0], q[WIDTH-1:1]};
                sout_d = q[0];
            end
            MODE_ASR: begin
                q_d    = {q[WIDTH-1], q[WIDTH-1:1]};
                sout_d = q[0];
            end
            MODE_CLR: begin
                q_d    = '0;
                sout_d = 1'b0;
            end
            default: begin
                q_d    = q;
                sout_d = sout;
            end
        endcase
    end

    dff_ar #(
        .WIDTH  (WIDTH),
        .RST_VAL(RST_VAL)
    ) u_q_reg (
        .clk(clk),
        .rst(rst),
        .en (en),
        .d  (q_d),
        .q  (q)
    );

    dff_ar #(
        .WIDTH  (1),
        .RST_VAL(1'b0)
    ) u_sout_reg (
        .clk(clk),
        .rst(rst),
        .en (en),
        .d  (sout_d),
        .q  (sout)
    );

    assign zero = (q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed scoreboard bench for univ_shift_reg (WIDTH=8, RST_VAL=8'hA5).
module tb_univ_shift_reg;
    import shift_pkg::*;

    localparam int         W    = 8;
    localparam logic [7:0] RSTV = 8'hA5;

    logic         clk;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_l;
    logic         sin_r;
    logic [W-1:0] q;
    logic         sout;
    logic         zero;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       sout;
    } exp_t;

    exp_t sb[$];
    event async_ev;
    int   n_checks;
    int   n_fail;

    univ_shift_reg #(
        .WIDTH  (W),
        .RST_VAL(RSTV)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .d    (d),
        .sin_l(sin_l),
        .sin_r(sin_r),
        .q    (q),
        .sout (sout),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation after each active edge or on an async-check request.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or async_ev);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks += 3;
                if (q !== e.q) begin
                    n_fail++;
                    $display("FAIL %s q: got %h expected %h", e.name, q, e.q);
                end
                if (sout !== e.sout) begin
                    n_fail++;
                    $display("FAIL %s sout: got %b expected %b", e.name, sout, e.sout);
                end
                if (zero !== (e.q == 8'h00)) begin
                    n_fail++;
                    $display("FAIL %s zero: got %b expected %b", e.name, zero, (e.q == 8'h00));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] m, input logic [7:0] dv, input logic sl,
                         input logic sr, input logic e, input logic [7:0] eq,
                         input logic es, input string nm);
        mode  = m;
        d     = dv;
        sin_l = sl;
        sin_r = sr;
        en    = e;
        sb.push_back('{nm, eq, es});
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] dv, input logic sl,
                      input logic sr, input logic e, input logic [7:0] eq,
                      input logic es, input string nm);
        @(negedge clk);
        issue(m, dv, sl, sr, e, eq, es, nm);
    endtask

    task automatic async_check(input logic [7:0] eq, input logic es, input string nm);
        sb.push_back('{nm, eq, es});
        -> async_ev;
    endtask

    localparam logic [7:0] ROL_Q [8] = '{8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96};
    localparam logic       ROL_S [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [7:0] ASR_Q [8] = '{8'hC8, 8'hE4, 8'hF2, 8'hF9, 8'hFC, 8'hFE, 8'hFF, 8'hFF};
    localparam logic       ASR_S [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        mode  = MODE_HOLD;
        d     = '0;
        sin_l = 1'b0;
        sin_r = 1'b0;

        #2;
        async_check(RSTV, 1'b0, "reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Load and shift
        op(MODE_LOAD, 8'h81, 0, 0, 1, 8'h81, 1'b0, "load_81");
        op(MODE_SHL,  8'h00, 0, 0, 1, 8'h02, 1'b1, "shl_0");
        op(MODE_SHR,  8'h00, 0, 1, 1, 8'h81, 1'b0, "shr_1");
        op(MODE_SHL,  8'h00, 1, 0, 1, 8'h03, 1'b1, "shl_1");

        // Asynchronous reset between edges
        @(negedge clk);
        en   = 1'b0;
        mode = MODE_HOLD;
        #2 rst = 1'b1;
        async_check(RSTV, 1'b0, "async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Rotate left full circle, then two rotates right
        op(MODE_LOAD, 8'h96, 0, 0, 1, 8'h96, 1'b0, "load_96");
        for (int i = 0; i < 8; i++)
            op(MODE_ROL, 8'h00, 0, 0, 1, ROL_Q[i], ROL_S[i], $sformatf("rol_%0d", i));
        op(MODE_ROR, 8'h00, 1, 1, 1, 8'h4B, 1'b0, "ror_0");
        op(MODE_ROR, 8'h00, 0, 0, 1, 8'hA5, 1'b1, "ror_1");

        // Arithmetic shift right converges to all-ones
        op(MODE_LOAD, 8'h90, 0, 0, 1, 8'h90, 1'b1, "load_90");
        for (int i = 0; i < 8; i++)
            op(MODE_ASR, 8'h00, 0, 0, 1, ASR_Q[i], ASR_S[i], $sformatf("asr_%0d", i));

        // Glitches between edges are ignored; HOLD is sampled at the edge
        op(MODE_HOLD, 8'h00, 0, 0, 1, 8'hFF, 1'b1, "hold_glitch");
        #1 mode = MODE_LOAD;
        #1 mode = MODE_CLR;
        #1 mode = MODE_HOLD;

        // Enable gating and clear
        op(MODE_LOAD, 8'h3C, 0, 0, 1, 8'h3C, 1'b1, "load_3c");
        for (int i = 0; i < 4; i++)
            op(MODE_CLR, 8'hFF, 1, 1, 0, 8'h3C, 1'b1, $sformatf("en0_clr_%0d", i));
        op(MODE_CLR, 8'h00, 0, 0, 1, 8'h00, 1'b0, "clr");
        op(MODE_SHL, 8'h00, 1, 1, 0, 8'h00, 1'b0, "en0_shl");

        // Reset in the middle of a shift run
        op(MODE_LOAD, 8'h01, 0, 0, 1, 8'h01, 1'b0, "load_01");
        op(MODE_SHL,  8'h00, 0, 0, 1, 8'h02, 1'b0, "shl_run_0");
        @(negedge clk);
        mode  = MODE_SHL;
        sin_l = 1'b0;
        en    = 1'b1;
        #2 rst = 1'b1;
        async_check(RSTV, 1'b0, "rst_mid_run");
        @(posedge clk);
        #3;
        async_check(RSTV, 1'b0, "rst_ignores_edge");
        @(negedge clk);
        rst = 1'b0;
        issue(MODE_SHL, 8'h00, 0, 0, 1, 8'h4A, 1'b1, "shl_after_rst");
        op(MODE_SHR, 8'h00, 0, 0, 1, 8'h25, 1'b0, "shr_after_rst");
        op(MODE_HOLD, 8'h00, 0, 0, 1, 8'h25, 1'b0, "hold_final");

        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
